// File: rtl/mux_capture_pkg.sv
// rtl/mux_capture_pkg.sv - shared types and constants for the mux capture FIFO
package mux_capture_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    localparam int                  DROP_CNT_W   = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mux_capture_mem.sv
// rtl/mux_capture_mem.sv - DEPTH x DATA_W storage, sync write, async read, no reset
module mux_capture_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mux_capture_fifo.sv
// rtl/mux_capture_fifo.sv - FWFT capture FIFO behind a 2:1 mux; MUX_CAPTURE_FIFO_STATS_EN adds drop_cnt
module mux_capture_fifo
    import mux_capture_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              full,
`ifdef MUX_CAPTURE_FIFO_STATS_EN
    output logic              empty,
    output logic [DROP_CNT_W-1:0] drop_cnt
`else
    output logic              empty
`endif
);

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    state_t            state_q, state_d;
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] mem_rdata;

    // All outputs decode from registered state; nothing passes combinationally from inputs.
    assign full      = (state_q == ST_FULL);
    assign empty     = (state_q == ST_EMPTY);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_rdata;
    assign count     = count_q;

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_ready && out_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_EMPTY: begin
                if (wr_en) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (rd_en && !wr_en && count_q == CNT_ONE) begin
                    state_d = ST_EMPTY;
                end else if (wr_en && !rd_en && count_q == CNT_LAST) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rd_en) state_d = ST_ACTIVE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

`ifdef MUX_CAPTURE_FIFO_STATS_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (in_valid && !in_ready && drop_q != DROP_CNT_MAX) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

    mux_capture_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mux_capture_fifo.sv
// tb/tb_mux_capture_fifo.sv - queue-model bench for mux_capture_fifo; MUX_CAPTURE_FIFO_STATS_EN enables drop_cnt checks
module tb_mux_capture_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
`ifdef MUX_CAPTURE_FIFO_STATS_EN
    logic [15:0]       drop_cnt;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
`ifdef MUX_CAPTURE_FIFO_STATS_EN
        .empty     (empty),
        .drop_cnt  (drop_cnt)
`else
        .empty     (empty)
`endif
    );

    // Reference: a plain queue of accepted words plus a saturating drop tally.
    logic [DATA_W-1:0] model_q [$];
    int                model_drop;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_q.delete();
            model_drop = 0;
        end else begin
            bit was_full, was_empty;
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (out_ready && !was_empty) void'(model_q.pop_front());
            if (in_valid && !was_full) model_q.push_back(in_data);
            if (in_valid && was_full && model_drop < 65535) model_drop++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int n;
        n = model_q.size();
        check("cmp_count", 32'(count), 32'(n));
        check("cmp_empty", 32'(empty), 32'(n == 0));
        check("cmp_full", 32'(full), 32'(n == DEPTH));
        check("cmp_in_ready", 32'(in_ready), 32'(n != DEPTH));
        check("cmp_out_valid", 32'(out_valid), 32'(n != 0));
        check("cmp_out_data", 32'(out_data), (n != 0) ? 32'(model_q[0]) : 32'h0);
`ifdef MUX_CAPTURE_FIFO_STATS_EN
        check("cmp_drop_cnt", 32'(drop_cnt), 32'(model_drop));
`endif
    end

    function automatic logic [DATA_W-1:0] mux2(input logic sel, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return sel ? a : b;
    endfunction

    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        rstn = 1'b1;

        // T2: order through the mux, a=1..3, sel=1
        for (int i = 1; i <= 3; i++) cyc(1'b1, mux2(1'b1, 8'(i), 8'hEE), 1'b0);
        check("t2_count", 32'(count), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            check("t2_order", 32'(out_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("t2_empty", 32'(empty), 32'd1);

        // T3: fill, drop 8'hAA, drain
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
        check("t3_full", 32'(full), 32'd1);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        check("t3_count", 32'(count), 32'd16);
        cyc(1'b1, 8'hAA, 1'b0);
        check("t3_count_hold", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_drain", 32'(out_data), 32'h10 + 32'(i));
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("t3_empty", 32'(empty), 32'd1);

        // T4: move pointers near the wrap, then 4 deep with simultaneous traffic
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b0);
        drain_all();
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("t4_head", 32'(out_data), 32'h40 + 32'(i));
            cyc(1'b1, 8'h44 + 8'(i), 1'b1);
            check("t4_count", 32'(count), 32'd4);
        end

        // T5: read while full drops the write; next write is accepted
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
        check("t5_full", 32'(full), 32'd1);
        cyc(1'b1, 8'hBB, 1'b1);
        check("t5_count15", 32'(count), 32'd15);
        cyc(1'b1, 8'hCC, 1'b0);
        check("t5_count16", 32'(count), 32'd16);
        drain_all();

        // Randomized phases with shifting write/read bias
        for (int p = 0; p < 6; p++) begin
            int wprob, rprob;
            wprob = (p % 3 == 0) ? 85 : (p % 3 == 1) ? 20 : 50;
            rprob = (p % 3 == 0) ? 20 : (p % 3 == 1) ? 85 : 50;
            for (int i = 0; i < 300; i++) begin
                logic [DATA_W-1:0] d;
                d = mux2(1'($urandom), 8'($urandom), 8'($urandom));
                cyc(1'($urandom_range(99) < wprob), d, 1'($urandom_range(99) < rprob));
            end
        end

        // T1: asynchronous reset with 5 entries held
        drain_all();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0);
        check("t1_count5", 32'(count), 32'd5);
        #2;
        rstn = 1'b0;
        #1;
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_out_data", 32'(out_data), 32'd0);
        check("t1_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc(1'b1, 8'h5A, 1'b0);
        check("t1_first", 32'(out_data), 32'h5A);
        check("t1_first_valid", 32'(out_valid), 32'd1);

`ifdef MUX_CAPTURE_FIFO_STATS_EN
        // T6: drop counter and saturation
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hDD, 1'b0);
        check("t6_drop3", 32'(drop_cnt), 32'd3);
        for (int i = 0; i < 70000; i++) cyc(1'b1, 8'hDD, 1'b0);
        check("t6_sat", 32'(drop_cnt), 32'hFFFF);
        cyc(1'b1, 8'hDD, 1'b0);
        check("t6_hold", 32'(drop_cnt), 32'hFFFF);
`endif

        cyc(1'b0, 8'h00, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
